// File: rtl/rob_param_if.sv
// Reorder buffer bus: allocation, CDB writeback, commit and status signals.
// master = instruction queue / CDB / commit side, slave = the ROB itself.
interface rob_param_if #(
   parameter int DEPTH     = 8,
   parameter int TAG_W     = $clog2(DEPTH),
   parameter int CDB_PORTS = 4,
   parameter int REG_W     = 5,
   parameter int DATA_W    = 32
);
   logic                        alloc_valid;
   logic [REG_W-1:0]            alloc_rd;
   logic                        alloc_is_store;
   logic                        alloc_is_br;
   logic                        alloc_ready;
   logic [TAG_W-1:0]            alloc_tag;
   logic [CDB_PORTS-1:0]        cdb_valid;
   logic [CDB_PORTS*TAG_W-1:0]  cdb_tag;
   logic [CDB_PORTS*DATA_W-1:0] cdb_data;
   logic [CDB_PORTS-1:0]        cdb_mispredict;
   logic                        commit_valid;
   logic                        commit_ready;
   logic [TAG_W-1:0]            commit_tag;
   logic [REG_W-1:0]            commit_rd;
   logic [DATA_W-1:0]           commit_data;
   logic                        commit_is_store;
   logic                        flush;
   logic [DEPTH-1:0]            entry_done;
   logic [TAG_W:0]              count;
   logic                        full;
   logic                        empty;

   modport master (
      output alloc_valid, alloc_rd, alloc_is_store, alloc_is_br,
      input  alloc_ready, alloc_tag,
      output cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
      input  commit_valid, commit_tag, commit_rd, commit_data,
      input  commit_is_store,
      output commit_ready,
      input  flush, entry_done, count, full, empty
   );

   modport slave (
      input  alloc_valid, alloc_rd, alloc_is_store, alloc_is_br,
      output alloc_ready, alloc_tag,
      input  cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
      output commit_valid, commit_tag, commit_rd, commit_data,
      output commit_is_store,
      input  commit_ready,
      output flush, entry_done, count, full, empty
   );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order alloc, CDB completion, in-order commit.
// Ports: clk, reset_n (async active-low), bus (rob_param_if.slave).
module rob_param #(
   parameter int DEPTH     = 8,
   parameter int TAG_W     = $clog2(DEPTH),
   parameter int CDB_PORTS = 4,
   parameter int REG_W     = 5,
   parameter int DATA_W    = 32
) (
   input logic        clk,
   input logic        reset_n,
   rob_param_if.slave bus
);
   localparam logic [TAG_W:0] ONE = {{TAG_W{1'b0}}, 1'b1};

   logic [TAG_W:0]     head_q;
   logic [TAG_W:0]     tail_q;
   logic [DEPTH-1:0]   valid_q;
   logic [DEPTH-1:0]   done_q;
   logic [DEPTH-1:0]   mis_q;
   logic [DEPTH-1:0]   br_q;
   logic [DEPTH-1:0]   st_q;
   logic [REG_W-1:0]   rd_q [DEPTH];
   logic [DATA_W-1:0]  data_q [DEPTH];
   logic               flush_q;

   logic [TAG_W-1:0]   hp;
   logic [TAG_W-1:0]   tp;
   logic               full;
   logic               alloc_ok;
   logic               commit_vld;
   logic               commit_ok;
   logic               do_flush;

   assign hp = head_q[TAG_W-1:0];
   assign tp = tail_q[TAG_W-1:0];

   // Wrap bits differ with equal index: tail has lapped head.
   assign full = (hp == tp) && (head_q[TAG_W] != tail_q[TAG_W]);

   assign alloc_ok   = bus.alloc_valid & ~full & ~flush_q;
   assign commit_vld = valid_q[hp] & done_q[hp];
   assign commit_ok  = commit_vld & bus.commit_ready;
   assign do_flush   = commit_ok & br_q[hp] & mis_q[hp];

   assign bus.alloc_ready     = ~full & ~flush_q;
   assign bus.alloc_tag       = tp;
   assign bus.commit_valid    = commit_vld;
   assign bus.commit_tag      = hp;
   assign bus.commit_rd       = rd_q[hp];
   assign bus.commit_data     = data_q[hp];
   assign bus.commit_is_store = st_q[hp];
   assign bus.flush           = flush_q;
   assign bus.entry_done      = valid_q & done_q;
   assign bus.count           = tail_q - head_q;
   assign bus.full            = full;
   assign bus.empty           = (head_q == tail_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
         done_q  <= '0;
         mis_q   <= '0;
         br_q    <= '0;
         st_q    <= '0;
         flush_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else if (do_flush) begin
         valid_q <= '0;
         done_q  <= '0;
         mis_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         flush_q <= 1'b1;
      end else begin
         flush_q <= 1'b0;
         // Walk ports high to low so the lowest index lands last and wins.
         for (int i = CDB_PORTS - 1; i >= 0; i--) begin
            if (bus.cdb_valid[i] &&
                valid_q[bus.cdb_tag[i*TAG_W +: TAG_W]]) begin
               done_q[bus.cdb_tag[i*TAG_W +: TAG_W]] <= 1'b1;
               data_q[bus.cdb_tag[i*TAG_W +: TAG_W]] <=
                  bus.cdb_data[i*DATA_W +: DATA_W];
               mis_q[bus.cdb_tag[i*TAG_W +: TAG_W]] <=
                  bus.cdb_mispredict[i] &
                  br_q[bus.cdb_tag[i*TAG_W +: TAG_W]];
            end
         end
         if (commit_ok) begin
            valid_q[hp] <= 1'b0;
            head_q      <= head_q + ONE;
         end
         // Tail slot is never valid when not full, so no CDB overlap.
         if (alloc_ok) begin
            valid_q[tp] <= 1'b1;
            done_q[tp]  <= 1'b0;
            mis_q[tp]   <= 1'b0;
            br_q[tp]    <= bus.alloc_is_br;
            st_q[tp]    <= bus.alloc_is_store;
            rd_q[tp]    <= bus.alloc_rd;
            tail_q      <= tail_q + ONE;
         end
      end
   end
endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_rob_param;
   localparam int DEPTH = 8;
   localparam int TW    = 3;
   localparam int CP    = 4;
   localparam int RW    = 5;
   localparam int DW    = 32;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rob_param_if #(.DEPTH(DEPTH), .TAG_W(TW), .CDB_PORTS(CP),
                  .REG_W(RW), .DATA_W(DW)) bus ();

   rob_param #(.DEPTH(DEPTH), .TAG_W(TW), .CDB_PORTS(CP),
               .REG_W(RW), .DATA_W(DW)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   typedef struct {
      int          tag;
      logic [4:0]  rd;
      bit          st;
      bit          br;
      bit          done;
      bit          mis;
      logic [31:0] data;
   } ent_t;

   ent_t q[$];
   int   ntag = 0;
   bit   mflush = 0;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic bit m_cv();
      return (q.size() > 0) && q[0].done && !mflush;
   endfunction

   task automatic model_clear();
      q.delete();
      ntag = 0;
      mflush = 0;
   endtask

   task automatic model_step();
      bit   cv;
      bit   ar;
      bit   claimed [DEPTH];
      int   t;
      cv = m_cv() && bus.commit_ready;
      ar = (q.size() < DEPTH) && !mflush;
      if (cv && q[0].br && q[0].mis) begin
         model_clear();
         mflush = 1;
         return;
      end
      mflush = 0;
      foreach (claimed[k]) claimed[k] = 0;
      for (int p = 0; p < CP; p++) begin
         if (bus.cdb_valid[p]) begin
            t = int'(bus.cdb_tag[p*TW +: TW]);
            if (!claimed[t]) begin
               claimed[t] = 1;
               foreach (q[k]) begin
                  if (q[k].tag == t) begin
                     q[k].done = 1;
                     q[k].data = bus.cdb_data[p*DW +: DW];
                     q[k].mis  = bus.cdb_mispredict[p] && q[k].br;
                  end
               end
            end
         end
      end
      if (cv) void'(q.pop_front());
      if (bus.alloc_valid && ar) begin
         q.push_back('{tag: ntag, rd: bus.alloc_rd,
                       st: bus.alloc_is_store, br: bus.alloc_is_br,
                       done: 0, mis: 0, data: 32'h0});
         ntag = (ntag + 1) % DEPTH;
      end
   endtask

   task automatic compare_all();
      logic [7:0] ed;
      ed = '0;
      foreach (q[k]) if (q[k].done) ed[q[k].tag] = 1'b1;
      check("count", bus.count, q.size());
      check("empty", bus.empty, q.size() == 0);
      check("full", bus.full, q.size() == DEPTH);
      check("alloc_ready", bus.alloc_ready,
            (q.size() < DEPTH) && !mflush);
      check("alloc_tag", bus.alloc_tag, ntag);
      check("flush", bus.flush, mflush);
      check("entry_done", bus.entry_done, ed);
      check("commit_valid", bus.commit_valid, m_cv());
      if (m_cv()) begin
         check("commit_tag", bus.commit_tag, q[0].tag);
         check("commit_rd", bus.commit_rd, q[0].rd);
         check("commit_data", bus.commit_data, q[0].data);
         check("commit_st", bus.commit_is_store, q[0].st);
      end
   endtask

   task automatic idle();
      bus.alloc_valid    = 0;
      bus.alloc_rd       = '0;
      bus.alloc_is_store = 0;
      bus.alloc_is_br    = 0;
      bus.cdb_valid      = '0;
      bus.cdb_tag        = '0;
      bus.cdb_data       = '0;
      bus.cdb_mispredict = '0;
      bus.commit_ready   = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic cdb(int p, int tag, logic [31:0] d, bit mis);
      bus.cdb_valid[p]          = 1'b1;
      bus.cdb_tag[p*TW +: TW]   = TW'(tag);
      bus.cdb_data[p*DW +: DW]  = d;
      bus.cdb_mispredict[p]     = mis;
   endtask

   task automatic alloc(int rd, bit st, bit br);
      bus.alloc_valid    = 1;
      bus.alloc_rd       = RW'(rd);
      bus.alloc_is_store = st;
      bus.alloc_is_br    = br;
   endtask

   // Called at a negedge; leaves the bench 4 time units later.
   task automatic do_reset();
      idle();
      reset_n = 0;
      #2;
      model_clear();
      check("rst_empty", bus.empty, 1);
      check("rst_cv", bus.commit_valid, 0);
      #2;
      reset_n = 1;
      compare_all();
   endtask

   initial begin
      bit seen5;
      int nfl;
      idle();
      @(negedge clk);
      do_reset();

      // Fill to full, then an ignored 9th alloc.
      for (int i = 0; i < DEPTH; i++) begin
         idle();
         alloc(i + 1, i[0], 0);
         tick();
      end
      check("fill_full", bus.full, 1);
      idle();
      alloc(31, 0, 0);
      tick();
      check("tail_held", bus.alloc_tag, 0);

      // Out-of-order completion, in-order commit.
      idle();
      bus.commit_ready = 1;
      cdb(0, 2, 32'h22, 0);
      tick();
      idle();
      bus.commit_ready = 1;
      cdb(0, 1, 32'h11, 0);
      tick();
      idle();
      bus.commit_ready = 1;
      cdb(0, 0, 32'h00, 0);
      tick();
      idle();
      bus.commit_ready = 1;
      repeat (3) tick();

      // Two ports name tag 5 in one cycle; port 0 must win.
      idle();
      bus.commit_ready = 1;
      cdb(0, 5, 32'hAA, 0);
      cdb(3, 5, 32'hBB, 0);
      tick();
      idle();
      bus.commit_ready = 1;
      cdb(1, 3, 32'h33, 0);
      cdb(2, 4, 32'h44, 0);
      tick();
      seen5 = 0;
      for (int i = 0; i < 6; i++) begin
         idle();
         bus.commit_ready = 1;
         if (bus.commit_valid && bus.commit_tag == 3'd5) begin
            seen5 = 1;
            check("dual_port_data", bus.commit_data, 32'hAA);
         end
         tick();
      end
      check("tag5_committed", seen5, 1);

      // Mispredicted branch at tag 3 with younger tags 4-6.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         idle();
         alloc(i + 8, 0, i == 3);
         tick();
      end
      idle();
      bus.commit_ready = 1;
      cdb(0, 0, 32'h100, 1);
      cdb(1, 1, 32'h101, 0);
      cdb(2, 2, 32'h102, 0);
      cdb(3, 3, 32'h103, 1);
      tick();
      nfl = 0;
      for (int i = 0; i < 8; i++) begin
         idle();
         bus.commit_ready = 1;
         alloc(1, 0, 0);
         if (bus.flush) nfl++;
         tick();
         if (bus.flush) begin
            idle();
            bus.commit_ready = 1;
            tick();
            check("post_flush_cnt", bus.count, 0);
            check("post_flush_tag", bus.alloc_tag, 0);
            nfl++;
            break;
         end
      end
      check("flush_len", nfl, 1);

      // Random traffic with commit_ready toggling every 3 cycles.
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         idle();
         if ($urandom % 4 != 0)
            alloc(int'($urandom % 32), $urandom % 2 == 0,
                  $urandom % 4 == 0);
         for (int p = 0; p < CP; p++) begin
            if ($urandom % 3 == 0) begin
               if (q.size() > 0)
                  cdb(p, q[$urandom % q.size()].tag, $urandom,
                      $urandom % 10 == 0);
               else
                  cdb(p, int'($urandom % DEPTH), $urandom, 0);
            end
         end
         bus.commit_ready = ((cyc / 3) % 2) == 0;
         tick();
      end

      // Asynchronous reset with 5 live entries, one complete.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         idle();
         alloc(i + 3, 0, 0);
         tick();
      end
      idle();
      cdb(0, 0, 32'h55, 0);
      tick();
      check("pre_rst_cv", bus.commit_valid, 1);
      idle();
      model_step();
      @(posedge clk);
      #3;
      reset_n = 0;
      #1;
      check("async_empty", bus.empty, 1);
      check("async_cv", bus.commit_valid, 0);
      check("async_count", bus.count, 0);
      model_clear();
      @(negedge clk);
      reset_n = 1;
      compare_all();
      idle();
      alloc(7, 0, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
